// File: rtl/acorn_pkg.sv
// Shared constants, FSM encoding and boolean helpers for the ACORN AD absorption block.
package acorn_pkg;

  localparam int unsigned STATE_W      = 293;
  localparam int unsigned PAD_STEPS    = 256;
  localparam int unsigned CA_PAD_STEPS = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PAD,
    ST_FIN
  } absorb_state_e;

  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

endpackage

// File: rtl/acorn_state_step.sv
// One combinational ACORN state update: LFSR taps, keystream, feedback, shift.
module acorn_state_step
  import acorn_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic               m,
  input  logic               ca,
  input  logic               cb,
  output logic [STATE_W-1:0] next_state
);

  logic [STATE_W-1:0] s;
  logic               ks;
  logic               f;

  always_comb begin
    s      = state;
    s[289] = s[289] ^ s[235] ^ s[230];
    s[230] = s[230] ^ s[196] ^ s[193];
    s[193] = s[193] ^ s[160] ^ s[154];
    s[154] = s[154] ^ s[111] ^ s[107];
    s[107] = s[107] ^ s[66]  ^ s[61];
    s[61]  = s[61]  ^ s[23]  ^ s[0];
    // Keystream uses the freshly updated LFSR taps.
    ks = s[12] ^ s[154] ^ maj(s[235], s[61], s[193]) ^ ch(s[230], s[111], s[66]);
    f  = s[0] ^ ~s[107] ^ maj(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks) ^ m;
    next_state = {f, s[STATE_W-1:1]};
  end

endmodule

// File: rtl/acorn_ad_absorb.sv
// ACORN associated-data absorption: streams AD words through UNROLL chained
// state steps, then runs the 256-step padding sequence.
module acorn_ad_absorb
  import acorn_pkg::*;
#(
  parameter int unsigned AD_W   = 32,
  parameter int unsigned UNROLL = 1,
  parameter int unsigned LEN_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] state_in,
  input  logic [LEN_W-1:0]   ad_len,
  input  logic [AD_W-1:0]    ad_data,
  input  logic               ad_valid,
  output logic               ad_ready,
  output logic [STATE_W-1:0] state_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned NB     = AD_W / 8;
  localparam int unsigned BITS_W = $clog2(AD_W + 1);
  localparam int unsigned PAD_W  = $clog2(PAD_STEPS + 1);

  if ((AD_W % 8) != 0 || (AD_W % UNROLL) != 0 ||
      !(AD_W == 8 || AD_W == 16 || AD_W == 32 || AD_W == 64 || AD_W == 128) ||
      !(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8) ||
      LEN_W < $clog2(NB + 1)) begin : g_param_check
    $error("acorn_ad_absorb: illegal AD_W/UNROLL/LEN_W combination");
  end

  absorb_state_e      fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [AD_W-1:0]    buf_q, buf_d;
  logic [BITS_W-1:0]  bits_q, bits_d;
  logic [PAD_W-1:0]   pad_q, pad_d;

  logic [LEN_W-1:0]   take;
  logic [UNROLL-1:0]  step_m, step_ca, step_cb;
  logic [PAD_W-1:0]   pad_idx;
  logic [STATE_W-1:0] step_out;

  always_comb begin
    step_m  = buf_q[UNROLL-1:0];
    step_ca = '1;
    step_cb = '1;
    pad_idx = '0;
    if (fsm_q == ST_PAD) begin
      for (int unsigned k = 0; k < UNROLL; k++) begin
        pad_idx    = pad_q + PAD_W'(k);
        step_m[k]  = (pad_idx == '0);
        step_ca[k] = (pad_idx < PAD_W'(CA_PAD_STEPS));
      end
    end
  end

  for (genvar g = 0; g < UNROLL; g++) begin : g_step
    logic [STATE_W-1:0] s_in, s_out;
    if (g == 0) begin : g_head
      assign s_in = state_q;
    end else begin : g_link
      assign s_in = g_step[g-1].s_out;
    end
    acorn_state_step u_step (
      .state      (s_in),
      .m          (step_m[g]),
      .ca         (step_ca[g]),
      .cb         (step_cb[g]),
      .next_state (s_out)
    );
  end

  assign step_out = g_step[UNROLL-1].s_out;

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    rem_d    = rem_q;
    buf_d    = buf_q;
    bits_d   = bits_q;
    pad_d    = pad_q;
    ad_ready = 1'b0;
    take     = (rem_q >= LEN_W'(NB)) ? LEN_W'(NB) : rem_q;

    unique case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = state_in;
          rem_d   = ad_len;
          buf_d   = '0;
          bits_d  = '0;
          pad_d   = '0;
          fsm_d   = (ad_len != '0) ? ST_ABSORB : ST_PAD;
        end
      end
      ST_ABSORB: begin
        if (bits_q == '0) begin
          ad_ready = (rem_q != '0);
          if (rem_q == '0) begin
            fsm_d = ST_PAD;
            pad_d = '0;
          end else if (ad_valid) begin
            buf_d  = ad_data;
            bits_d = BITS_W'({take, 3'b000});
            rem_d  = rem_q - take;
          end
        end else begin
          state_d = step_out;
          buf_d   = buf_q >> UNROLL;
          bits_d  = bits_q - BITS_W'(UNROLL);
          // Leave straight from the last absorb cycle so no idle cycle precedes padding.
          if (bits_d == '0 && rem_q == '0) begin
            fsm_d = ST_PAD;
            pad_d = '0;
          end
        end
      end
      ST_PAD: begin
        state_d = step_out;
        pad_d   = pad_q + PAD_W'(UNROLL);
        if (pad_d == PAD_W'(PAD_STEPS)) fsm_d = ST_FIN;
      end
      ST_FIN: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      bits_q  <= '0;
      pad_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
      bits_q  <= bits_d;
      pad_q   <= pad_d;
    end
  end

  assign state_out = state_q;
  assign busy      = (fsm_q != ST_IDLE);
  assign done      = (fsm_q == ST_FIN);

endmodule

// File: doc/acorn_ad_absorb.md
ACORN_AD_ABSORB -- requirements
Module: acorn_ad_absorb

Interface
REQ-001 SHALL have parameter AD_W, default 32, AD input word width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL have parameter UNROLL, default 1, ACORN steps per clock; legal values 1, 2, 4, 8.
REQ-003 SHALL have parameter LEN_W, default 16, width of the AD byte-length field.
REQ-004 SHALL have port clk, input, 1, clock; reset rst, asynchronous, active-low.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, single-cycle request to begin AD absorption.
REQ-007 SHALL have port state_in, input, 293, initial cipher state, sampled on accepted start.
REQ-008 SHALL have port ad_len, input, LEN_W, AD length in bytes, sampled on accepted start.
REQ-009 SHALL have port ad_data, input, AD_W, AD word; byte k in bits [8k+7:8k], LSB of each byte absorbed first.
REQ-010 SHALL have ports ad_valid (input, 1) and ad_ready (output, 1), forming a valid/ready handshake for ad_data.
REQ-011 SHALL have port state_out, output, 293, current/final cipher state.
REQ-012 SHALL have ports busy (output, 1), high outside IDLE, and done (output, 1), a one-cycle completion pulse.

Function
REQ-013 SHALL implement the FSM IDLE -> ABSORB -> PAD -> FIN -> IDLE.
REQ-014 In IDLE, start SHALL latch state_in and ad_len; the FSM SHALL go to ABSORB if ad_len>0, else directly to PAD.
REQ-015 start SHALL be ignored outside IDLE.
REQ-016 In ABSORB, ad_ready SHALL be 1 only when the word buffer is empty and remaining bytes>0; a handshake loads the word, and absorption starts the next cycle.
REQ-017 Each ABSORB cycle SHALL apply UNROLL sequential steps with m = next AD bits, ca=1, cb=1.
REQ-018 A full word SHALL take 1+AD_W/UNROLL cycles; on the final word, bytes beyond ad_len SHALL be discarded and only the remaining bits absorbed.
REQ-019 The remaining-byte counter SHALL decrement by min(AD_W/8, remaining) per accepted word; it SHALL never wrap below zero.
REQ-020 When remaining bytes reach 0 and the buffer is empty, the FSM SHALL enter PAD.
REQ-021 PAD SHALL run a pad index p=0..255, advancing UNROLL steps per cycle: m=1 at p=0, else m=0; ca=1 for p<128, else 0; cb=1 throughout; PAD lasts 256/UNROLL cycles.
REQ-022 FIN SHALL last one cycle, assert done=1, and return to IDLE.
REQ-023 state_out SHALL equal the working state register at all times and SHALL hold the final state in IDLE until the next accepted start.
REQ-024 ad_valid with no remaining bytes, or outside ABSORB, SHALL be ignored (ad_ready=0).
REQ-025 ad_len=0 SHALL take exactly 256/UNROLL+1 cycles from start to done.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE and clear the state register, counters and buffer, setting state_out=0, ad_ready=0, busy=0, done=0.
REQ-027 Reset mid-operation SHALL abandon the operation with no done pulse; the next start after release SHALL behave as from power-up.

Structure
REQ-028 Package acorn_pkg SHALL hold STATE_W=293, PAD_STEPS=256, CA_PAD_STEPS=128 and the FSM state enum.
REQ-029 Sub-module acorn_state_step (combinational single step: state, m, ca, cb -> next state) SHALL be instantiated UNROLL times in a chain.
REQ-030 Parameter legality (AD_W % UNROLL==0, AD_W%8==0) SHALL be checked at elaboration.

Verification
REQ-031 UNROLL=1, AD_W=32, ad_len=16, always-valid random AD -> 4 handshakes, done 389 cycles after start, state_out == golden model.
REQ-032 ad_len=0, UNROLL=1 -> no ad_ready, done exactly 257 cycles after start, state_out == golden pad-only result.
REQ-033 ad_len=5, AD_W=32 -> 2 words accepted, upper 3 bytes of word 2 varied randomly with no effect on state_out.
REQ-034 UNROLL=8, AD_W=64, ad_len=24, ad_valid toggled randomly -> state_out identical to the UNROLL=1 run on the same data.
REQ-035 rst pulsed in PAD, then a new start -> outputs 0 during reset, no done, second run matches golden.
REQ-036 start reasserted while busy -> ignored; ad_len/state_in changes after start have no effect on the result.
